// File: rtl/sll_iter_32_pkg.sv
// sll_iter_32_pkg
//   Shared definitions for the iterative 32-bit logical left shifter:
//   FSM state encodings, datapath widths and the final stage index.
//   No ports.

package sll_iter_32_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  // The stage index counts down from SHAMT_W-1. The operation finishes when
  // this index has been processed.
  localparam logic [2:0] FIRST_IDX = 3'd4;
  localparam logic [2:0] LAST_IDX  = 3'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sll_iter_32_lshift_stage.sv
// lshift_stage_32
//   One combinational power-of-two left-shift stage with zero fill.
//   Ports:
//     in    [31:0]  value entering the stage
//     en            apply the shift when high, pass through when low
//     out   [31:0]  in << N when enabled, otherwise in
//     spill         high when enabled and any of the N discarded MSBs is 1
//   Parameter N: shift distance, 1..16.

module lshift_stage_32
  import sll_iter_32_pkg::*;
#(
  parameter int N = 1
) (
  input  logic [WIDTH-1:0] in,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic             spill
);

  assign out   = en ? (in << N) : in;
  assign spill = en & (|in[WIDTH-1 -: N]);

endmodule

// File: rtl/sll_iter_32.sv
// sll_iter_32
//   Iterative 32-bit logical left shifter. One stage is applied per clock,
//   in the order 16, 8, 4, 2, 1. This gives a fixed 5-clock latency from the
//   accepting edge to done.
//   Ports:
//     clock          rising-edge clock
//     reset          asynchronous active-high reset
//     start          request, sampled only in IDLE or DONE
//     a      [31:0]  operand, latched on the accepting edge
//     shamt  [4:0]   shift amount, latched on the accepting edge
//     busy           high while stages are being applied
//     done           one-cycle pulse when result/lost are final
//     result [31:0]  shift register contents (partial while busy)
//     lost           a 1-bit has been shifted out past bit 31

module sll_iter_32 #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               lost
);
  import sll_iter_32_pkg::*;

  state_t             r_state;
  logic [2:0]         r_idx;
  logic [WIDTH-1:0]   r_shreg;
  logic [SHAMT_W-1:0] r_amt;
  logic               r_lost;
  logic               r_busy;
  logic               r_done;

  logic [WIDTH-1:0]   w_stage_out [SHAMT_W];
  logic [SHAMT_W-1:0] w_stage_spill;
  logic [WIDTH-1:0]   w_next;
  logic               w_spill;
  logic               w_accept;

  // Stage k shifts by 2**k. Only the stage picked by r_idx is used each cycle.
  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    lshift_stage_32 #(.N(1 << k)) u_stage (
      .in    (r_shreg),
      .en    (r_amt[k]),
      .out   (w_stage_out[k]),
      .spill (w_stage_spill[k])
    );
  end

  always_comb begin
    w_next  = r_shreg;
    w_spill = 1'b0;
    case (r_idx)
      3'd4: begin w_next = w_stage_out[4]; w_spill = w_stage_spill[4]; end
      3'd3: begin w_next = w_stage_out[3]; w_spill = w_stage_spill[3]; end
      3'd2: begin w_next = w_stage_out[2]; w_spill = w_stage_spill[2]; end
      3'd1: begin w_next = w_stage_out[1]; w_spill = w_stage_spill[1]; end
      3'd0: begin w_next = w_stage_out[0]; w_spill = w_stage_spill[0]; end
      default: begin w_next = r_shreg; w_spill = 1'b0; end
    endcase
  end

  assign w_accept = start && (r_state != S_SHIFT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= FIRST_IDX;
      r_shreg <= '0;
      r_amt   <= '0;
      r_lost  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_shreg <= a;
            r_amt   <= shamt;
            r_lost  <= 1'b0;
            r_idx   <= FIRST_IDX;
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          r_shreg <= w_next;
          r_lost  <= r_lost | w_spill;
          if (r_idx == LAST_IDX) begin
            // Park the index at its start value so it is ready for the next operation.
            r_idx   <= FIRST_IDX;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx - 3'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_shreg;
  assign lost   = r_lost;

endmodule

// File: tb/tb_sll_iter_32.sv
module tb_sll_iter_32;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        lost;

  int n_assert = 0;
  int n_fail   = 0;
  int n_done;
  int gap;

  sll_iter_32 dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .shamt  (shamt),
    .busy   (busy),
    .done   (done),
    .result (result),
    .lost   (lost)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full operation: issue at a negedge, check busy after E0, no done
  // through E4, and done plus the final values after E5.
  task automatic run_op(input string tag, input logic [31:0] av, input logic [4:0] sv,
                        input logic [31:0] exp_res, input logic exp_lost);
    @(negedge clock);
    start = 1'b1; a = av; shamt = sv;
    @(posedge clock); #1;
    start = 1'b0; a = 32'hXXXX_XXXX; shamt = 5'bxxxxx;
    chk({tag, " busy after E0"}, {31'd0, busy}, 32'd1);
    repeat (4) @(posedge clock);
    #1;
    chk({tag, " no done at E4"}, {31'd0, done}, 32'd0);
    @(posedge clock); #1;
    chk({tag, " done at E5"}, {31'd0, done}, 32'd1);
    chk({tag, " busy low in done"}, {31'd0, busy}, 32'd0);
    chk({tag, " result"}, result, exp_res);
    chk({tag, " lost"}, {31'd0, lost}, {31'd0, exp_lost});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; a = '0; shamt = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset result", result, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      chk("idle busy", {31'd0, busy}, 32'd0);
      chk("idle done", {31'd0, done}, 32'd0);
      chk("idle result", result, 32'd0);
      chk("idle lost", {31'd0, lost}, 32'd0);
    end

    run_op("basic", 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0);
    run_op("ovf1",  32'h8000_0001, 5'd1,  32'h0000_0002, 1'b1);
    run_op("ovf16", 32'hFFFF_FFFF, 5'd16, 32'hFFFF_0000, 1'b1);
    run_op("mix5",  32'hA5A5_A5A5, 5'd5,  32'hB4B4_B4A0, 1'b1);
    run_op("zero",  32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0);

    // Result and lost hold in IDLE.
    repeat (3) @(posedge clock);
    #1;
    chk("hold result", result, 32'h1234_5678);
    chk("hold done", {31'd0, done}, 32'd0);

    // Start pulses during SHIFT are ignored and produce exactly one done.
    @(negedge clock);
    start = 1'b1; a = 32'h0000_00F0; shamt = 5'd2;
    n_done = 0;
    @(posedge clock); #1;
    start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clock);
      if (i == 1 || i == 3) begin start = 1'b1; a = 32'hDEAD_BEEF; shamt = 5'd7; end
      else start = 1'b0;
      @(posedge clock); #1;
      if (done) begin
        n_done++;
        chk("ignore done timing", i, 5);
        chk("ignore result", result, 32'h0000_03C0);
        chk("ignore lost", {31'd0, lost}, 32'd0);
      end
    end
    chk("ignore done count", n_done, 1);

    // Back-to-back with start held high.
    @(negedge clock);
    start = 1'b1; a = 32'h0000_00FF; shamt = 5'd4;
    @(posedge clock); #1;
    gap = 0;
    n_done = 0;
    for (int i = 1; i <= 20 && n_done < 2; i++) begin
      @(posedge clock); #1;
      gap++;
      chk("b2b busy/done exclusive", {31'd0, busy & done}, 32'd0);
      if (done) begin
        n_done++;
        if (n_done == 1) begin
          chk("b2b first latency", gap, 5);
          chk("b2b first result", result, 32'h0000_0FF0);
          chk("b2b first lost", {31'd0, lost}, 32'd0);
          a = 32'h0F00_0000; shamt = 5'd8;
          gap = 0;
        end else begin
          chk("b2b spacing", gap, 6);
          chk("b2b second result", result, 32'h0000_0000);
          chk("b2b second lost", {31'd0, lost}, 32'd1);
        end
      end
      if (n_done == 1 && gap == 1) start = 1'b0;
    end
    chk("b2b done count", n_done, 2);
    start = 1'b0;

    // Asynchronous reset between E2 and E3 aborts the operation.
    @(negedge clock);
    start = 1'b1; a = 32'h0000_0003; shamt = 5'd3;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort result", result, 32'd0);
    chk("abort lost", {31'd0, lost}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    n_done = 0;
    repeat (8) begin
      @(posedge clock); #1;
      if (done) n_done++;
    end
    chk("abort no done", n_done, 0);
    run_op("restart", 32'h0000_0003, 5'd3, 32'h0000_0018, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sll_iter_32.md
# sll_iter_32

Iterative 32-bit logical left shifter for the processor's multicycle execute path, the left-direction counterpart to the existing arithmetic right-shift stages. It accepts an operand and a 5-bit shift amount under a start/done handshake, then applies one power-of-two left-shift stage per clock (16, 8, 4, 2, 1). Result and status are held until the next operation. This keeps the ALU's critical path to a single 32-bit 2:1 mux level.

## Interface
Parameters:
- WIDTH, 32, operand/result width; fixed at 32, other values unsupported.
- SHAMT_W, 5, shift-amount width; equals log2(WIDTH).

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  32  operand; latched on the accepting edge.
- shamt  input  5  shift amount; latched on the accepting edge.
- busy  output  1  high in SHIFT.
- done  output  1  one-cycle pulse, high exactly while in DONE.
- result  output  32  shifted value; held stable outside SHIFT.
- lost  output  1  high if any 1-bit was shifted out past bit 31; held with result.

## Operation
- The FSM has three states: IDLE, SHIFT, DONE. Reset puts it in IDLE.
- Reset values: busy=0, done=0, result=0, lost=0, stage index=4, latched shamt=0.
- Accept: start=1 in IDLE or DONE. On that edge the block latches shreg<=a and amt<=shamt, clears lost, sets idx=4, and moves to SHIFT.
- start in SHIFT is ignored. It is neither queued nor an error.
- SHIFT, each edge:
  - if amt[idx]=1: shreg<=shreg<<(1<<idx), zero-filled, and lost |= OR of the (1<<idx) MSBs being discarded.
  - if amt[idx]=0: shreg is unchanged.
  - idx decrements by one.
  - On the edge where idx=0 is processed, the state moves to DONE.
- DONE lasts one cycle. The next edge goes to SHIFT if start=1 (back-to-back), else to IDLE.
- result is driven directly from shreg. During SHIFT it shows partial values, and consumers must qualify it with done.
- Arithmetic:
  - The operation is a pure logical left shift mod 2^32, i.e. result = (a << shamt) & 0xFFFFFFFF.
  - lost = |(a >> (32 - shamt)) for shamt>0; lost=0 for shamt=0.
- shamt=0 uses the full latency. There is no early exit, so latency is deterministic.
- Reset mid-SHIFT aborts the operation at once: outputs go to their reset values and done is never produced.

## Timing
- Accepting edge E0. Stage edges E1..E5 apply shifts of 16, 8, 4, 2 and 1 respectively.
- done=1 and the final result are valid in the cycle after E5: a fixed latency of 5 clocks from the accepting edge.
- busy=1 from after E0 through E5, and busy and done are never both high.
- Back-to-back throughput: start held high in DONE yields one result every 6 clocks.
- a and shamt may change freely after E0.

## Structure
- Shared header/package holds:
  - state encodings S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2;
  - constants WIDTH=32, SHAMT_W=5, LAST_IDX=0.
- One combinational sub-module, lshift_stage_32 (inputs in[31:0], en, parameter N; outputs out[31:0], spill):
  - out = en ? in<<N : in;
  - spill = en & |in[31:32-N].
  - The top level instantiates five of them, N=16/8/4/2/1, and selects by idx. Alternatively, one variable-N mux stage is acceptable if it matches the same function.
- Top level holds only the FSM, idx counter, shreg, amt and lost.

## Test plan
- Reset then idle: with reset asserted, then released, and no start → busy=0, done=0, result=0, lost=0 for 10 cycles.
- Basic shift: a=0x0000_0001, shamt=31 → done 5 clocks after the accepting edge, result=0x8000_0000, lost=0.
- Overflow: a=0x8000_0001, shamt=1 → result=0x0000_0002, lost=1. Then a=0xFFFF_FFFF, shamt=16 → result=0xFFFF_0000, lost=1.
- Zero shift and busy-ignore:
  - a=0x1234_5678, shamt=0 → result=0x1234_5678, lost=0, still 5-clock latency.
  - start pulses during SHIFT with a=0xDEAD_BEEF → ignored, with exactly one done.
- Back-to-back: start held high with a=0x0000_00FF, shamt=4, then a=0x0F00_0000, shamt=8 on the DONE cycle → results 0x0000_0FF0 (lost=0) then 0x0000_0000 (lost=1), done pulses 6 clocks apart.
- Reset mid-operation: start with a=0x0000_0003, shamt=3, assert reset asynchronously between edges E2 and E3 → outputs immediately reset values, no done. Restart after release completes normally with result=0x0000_0018.
